endpoint_link: RTL and testbench

ENDPOINT_LINK -- requirements
Module: endpoint_link

---
 rtl/endpoint_link.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_endpoint_link.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/endpoint_link.sv
// rtl/endpoint_link.sv - credit-based endpoint link between a local client and one switch port
//
// Purpose: the link sends local flits into the switch input buffer under per-VC
// credit flow control. It also buffers flits coming out of the switch in per-VC
// receive FIFOs and hands them to a local consumer in round-robin VC order.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   sw_in / sw_data_ready_in          registered flit toward the switch, one-cycle valid pulse
//   sw_buffer_available               per-VC credit-return pulses from the switch
//   sw_out / sw_data_ready_out        flit from the switch outport and its valid
//   sw_credit_granted                 per-VC pulse, one RX slot freed by a pop
//   sw_packet_sent                    pulse, consumer popped the last flit of a packet
//   sw_config_done                    switch configured; gates transmission
//   tx_flit / tx_valid / tx_ready     local transmit handshake
//   rx_flit / rx_valid / rx_ready     local receive handshake; rx_eop marks end of packet
//   err_credit, err_overflow          sticky error flags, cleared only by rst

package endpoint_link_pkg;
  localparam int FLIT_VC_W   = 2;
  localparam int FLIT_DATA_W = 16;

  typedef struct packed {
    logic [FLIT_VC_W-1:0]   vc;
    logic [FLIT_DATA_W-1:0] data;
  } flit_t;
endpackage

module endpoint_link
  import endpoint_link_pkg::*;
#(
  parameter int NUM_VCS    = 2,
  parameter int TX_CREDITS = 4,
  parameter int RX_DEPTH   = 4   // power of two, at least 2
) (
  input  logic               clk,
  input  logic               rst,
  output flit_t              sw_in,
  output logic               sw_data_ready_in,
  input  logic [NUM_VCS-1:0] sw_buffer_available,
  input  flit_t              sw_out,
  input  logic               sw_data_ready_out,
  output logic [NUM_VCS-1:0] sw_credit_granted,
  output logic               sw_packet_sent,
  input  logic               sw_config_done,
  input  flit_t              tx_flit,
  input  logic               tx_valid,
  output logic               tx_ready,
  output flit_t              rx_flit,
  output logic               rx_valid,
  input  logic               rx_ready,
  input  logic               rx_eop,
  output logic               err_credit,
  output logic               err_overflow
);

  localparam int VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int CW = $clog2(TX_CREDITS + 1);
  localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

  localparam logic [CW-1:0] CREDIT_MAX = CW'(TX_CREDITS);
  localparam logic [VW-1:0] LAST_VC    = VW'(NUM_VCS - 1);

  // ---------------------------------------------------------------------------
  // Link state machine
  // ---------------------------------------------------------------------------
  typedef enum logic {
    WAIT_CFG = 1'b0,
    ACTIVE   = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   link_active;
  logic   load_credits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_CFG;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_CFG: if (sw_config_done)  state_d = ACTIVE;
      ACTIVE:   if (!sw_config_done) state_d = WAIT_CFG;
      default:  state_d = WAIT_CFG;
    endcase
  end

  always_comb begin
    link_active  = (state_q == ACTIVE);
    // Credits are reloaded on the edge that enters ACTIVE, so any credit state
    // left over from a previous configuration is discarded.
    load_credits = (state_q == WAIT_CFG) && sw_config_done;
  end

  // ---------------------------------------------------------------------------
  // Transmit path and credit counters
  // ---------------------------------------------------------------------------
  logic [CW-1:0]      credit_q [NUM_VCS];
  logic [CW-1:0]      credit_d [NUM_VCS];
  logic [VW-1:0]      tx_vc;
  logic               tx_vc_ok;
  logic               tx_accept;
  logic [NUM_VCS-1:0] tx_dec;
  logic               err_credit_q, err_credit_d;
  flit_t              sw_in_q;
  logic               sw_data_ready_in_q;

  assign tx_vc     = tx_flit.vc[VW-1:0];
  assign tx_vc_ok  = (int'(tx_flit.vc) < NUM_VCS);
  assign tx_ready  = link_active && tx_vc_ok && (credit_q[tx_vc] != '0);
  assign tx_accept = tx_valid && tx_ready;

  always_comb begin
    err_credit_d = err_credit_q;
    for (int v = 0; v < NUM_VCS; v++) begin
      tx_dec[v]   = tx_accept && (tx_vc == VW'(v));
      credit_d[v] = credit_q[v];
      if (load_credits) begin
        credit_d[v] = CREDIT_MAX;
      end else if (sw_buffer_available[v] && !tx_dec[v]) begin
        // A return with every slot already credited means the switch and the
        // endpoint disagree; saturate rather than wrap.
        if (credit_q[v] == CREDIT_MAX) begin
          err_credit_d = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] + 1'b1;
        end
      end else if (tx_dec[v] && !sw_buffer_available[v]) begin
        credit_d[v] = credit_q[v] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        credit_q[v] <= '0;
      end
      err_credit_q       <= 1'b0;
      sw_in_q            <= '0;
      sw_data_ready_in_q <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        credit_q[v] <= credit_d[v];
      end
      err_credit_q       <= err_credit_d;
      sw_data_ready_in_q <= tx_accept;
      if (tx_accept) begin
        sw_in_q <= tx_flit;
      end
    end
  end

  assign sw_in            = sw_in_q;
  assign sw_data_ready_in = sw_data_ready_in_q;
  assign err_credit       = err_credit_q;

  // ---------------------------------------------------------------------------
  // Receive FIFOs, one per VC. Pointers carry one extra wrap bit so that
  // full and empty are distinguishable without a separate count.
  // ---------------------------------------------------------------------------
  flit_t              mem_q    [NUM_VCS][RX_DEPTH];
  logic [AW:0]        wr_ptr_q [NUM_VCS];
  logic [AW:0]        rd_ptr_q [NUM_VCS];
  logic [NUM_VCS-1:0] fifo_empty;
  logic [NUM_VCS-1:0] fifo_full;

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      fifo_empty[v] = (wr_ptr_q[v] == rd_ptr_q[v]);
      fifo_full[v]  = (wr_ptr_q[v][AW] != rd_ptr_q[v][AW]) &&
                      (wr_ptr_q[v][AW-1:0] == rd_ptr_q[v][AW-1:0]);
    end
  end

  // Round-robin search: first non-empty VC at or after the pointer.
  logic [VW-1:0] rr_q, rr_d;
  logic [VW-1:0] rr_vc;
  logic [VW-1:0] cand_vc;
  int            cand;
  logic          rr_found;

  always_comb begin
    rr_found = 1'b0;
    rr_vc    = '0;
    cand     = 0;
    cand_vc  = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= NUM_VCS) begin
        cand = cand - NUM_VCS;
      end
      cand_vc = VW'(cand);
      if (!rr_found && !fifo_empty[cand_vc]) begin
        rr_found = 1'b1;
        rr_vc    = cand_vc;
      end
    end
  end

  // Once a flit is offered but not taken, the offered VC is locked so a push
  // into a VC nearer the pointer cannot swap rx_flit under a stalled consumer.
  logic               lock_q, lock_d;
  logic [VW-1:0]      lock_vc_q;
  logic [VW-1:0]      sel_vc;
  logic               pop;
  logic [VW-1:0]      push_vc;
  logic               push_req;
  logic               push_en;
  logic               push_drop;
  logic [NUM_VCS-1:0] granted_d;
  logic [NUM_VCS-1:0] sw_credit_granted_q;
  logic               sw_packet_sent_q;
  logic               err_overflow_q;

  assign sel_vc   = lock_q ? lock_vc_q : rr_vc;
  assign rx_valid = ~&fifo_empty;
  assign rx_flit  = rx_valid ? mem_q[sel_vc][rd_ptr_q[sel_vc][AW-1:0]] : '0;
  assign pop      = rx_valid && rx_ready;
  assign lock_d   = rx_valid && !rx_ready;

  assign push_vc  = sw_out.vc[VW-1:0];
  assign push_req = sw_data_ready_out && (int'(sw_out.vc) < NUM_VCS);
  // A full FIFO still accepts when its head leaves on the same edge.
  assign push_en   = push_req && (!fifo_full[push_vc] || (pop && (sel_vc == push_vc)));
  assign push_drop = push_req && !push_en;

  always_comb begin
    rr_d = rr_q;
    if (pop) begin
      rr_d = (sel_vc == LAST_VC) ? '0 : sel_vc + 1'b1;
    end
    for (int v = 0; v < NUM_VCS; v++) begin
      granted_d[v] = pop && (sel_vc == VW'(v));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
      end
      rr_q                <= '0;
      lock_q              <= 1'b0;
      lock_vc_q           <= '0;
      sw_credit_granted_q <= '0;
      sw_packet_sent_q    <= 1'b0;
      err_overflow_q      <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (push_en && (push_vc == VW'(v))) begin
          wr_ptr_q[v] <= wr_ptr_q[v] + 1'b1;
        end
        if (granted_d[v]) begin
          rd_ptr_q[v] <= rd_ptr_q[v] + 1'b1;
        end
      end
      rr_q                <= rr_d;
      lock_q              <= lock_d;
      lock_vc_q           <= sel_vc;
      sw_credit_granted_q <= granted_d;
      sw_packet_sent_q    <= pop && rx_eop;
      err_overflow_q      <= err_overflow_q | push_drop;
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[push_vc][wr_ptr_q[push_vc][AW-1:0]] <= sw_out;
    end
  end

  assign sw_credit_granted = sw_credit_granted_q;
  assign sw_packet_sent    = sw_packet_sent_q;
  assign err_overflow      = err_overflow_q;

endmodule

// File: tb/tb_endpoint_link.sv
// tb/tb_endpoint_link.sv - scoreboard bench for endpoint_link
module tb_endpoint_link;
  import endpoint_link_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  flit_t      sw_in;
  logic       sw_data_ready_in;
  logic [1:0] sw_buffer_available = '0;
  flit_t      sw_out = '0;
  logic       sw_data_ready_out = 1'b0;
  logic [1:0] sw_credit_granted;
  logic       sw_packet_sent;
  logic       sw_config_done = 1'b0;
  flit_t      tx_flit = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  flit_t      rx_flit;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_eop = 1'b0;
  logic       err_credit;
  logic       err_overflow;

  int total = 0;
  int bad   = 0;

  flit_t tx_q[$];
  flit_t rx_q[$];

  logic       exp_dri = 1'b0;
  logic [1:0] exp_cg  = '0;
  logic       exp_ps  = 1'b0;

  endpoint_link #(.NUM_VCS(2), .TX_CREDITS(4), .RX_DEPTH(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .sw_in               (sw_in),
    .sw_data_ready_in    (sw_data_ready_in),
    .sw_buffer_available (sw_buffer_available),
    .sw_out              (sw_out),
    .sw_data_ready_out   (sw_data_ready_out),
    .sw_credit_granted   (sw_credit_granted),
    .sw_packet_sent      (sw_packet_sent),
    .sw_config_done      (sw_config_done),
    .tx_flit             (tx_flit),
    .tx_valid            (tx_valid),
    .tx_ready            (tx_ready),
    .rx_flit             (rx_flit),
    .rx_valid            (rx_valid),
    .rx_ready            (rx_ready),
    .rx_eop              (rx_eop),
    .err_credit          (err_credit),
    .err_overflow        (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic flit_t mk(input logic [1:0] vc, input logic [15:0] d);
    flit_t f;
    f.vc   = vc;
    f.data = d;
    return f;
  endfunction

  // Scoreboard side: outputs toward the switch and toward the consumer.
  always @(negedge clk) begin
    flit_t e;
    if (rst) begin
      exp_dri = 1'b0;
      exp_cg  = '0;
      exp_ps  = 1'b0;
    end else begin
      check("sw_data_ready_in", 32'(sw_data_ready_in), 32'(exp_dri));
      if (sw_data_ready_in) begin
        if (tx_q.size() == 0) check("sw_in_unexpected", 32'd1, 32'd0);
        else check("sw_in", 32'(sw_in), 32'(tx_q.pop_front()));
      end
      check("sw_credit_granted", 32'(sw_credit_granted), 32'(exp_cg));
      check("sw_packet_sent", 32'(sw_packet_sent), 32'(exp_ps));
      exp_dri = tx_valid && tx_ready;
      exp_cg  = '0;
      exp_ps  = 1'b0;
      if (rx_valid && rx_ready) begin
        if (rx_q.size() == 0) begin
          check("rx_unexpected", 32'd1, 32'd0);
        end else begin
          e = rx_q.pop_front();
          check("rx_flit", 32'(rx_flit), 32'(e));
          exp_cg[e.vc[0]] = 1'b1;
          exp_ps = rx_eop;
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tx_step(input logic [1:0] vc, input logic [15:0] d, input logic exp_rdy);
    tx_valid = 1'b1;
    tx_flit  = mk(vc, d);
    @(negedge clk);
    check("tx_ready", 32'(tx_ready), 32'(exp_rdy));
    if (exp_rdy) tx_q.push_back(tx_flit);
    cycle();
  endtask

  task automatic credit_pulse(input logic [1:0] mask);
    sw_buffer_available = mask;
    cycle();
    sw_buffer_available = '0;
  endtask

  task automatic rx_push(input logic [1:0] vc, input logic [15:0] d, input logic expect_kept);
    sw_out            = mk(vc, d);
    sw_data_ready_out = 1'b1;
    if (expect_kept) rx_q.push_back(sw_out);
    cycle();
    sw_data_ready_out = 1'b0;
  endtask

  task automatic rx_drain();
    rx_ready = 1'b1;
    for (int i = 0; i < 40 && rx_q.size() != 0; i++) cycle();
    rx_ready = 1'b0;
    check("rx_drain_left", 32'(rx_q.size()), 32'd0);
    @(negedge clk);
    check("rx_valid_after_drain", 32'(rx_valid), 32'd0);
    cycle();
  endtask

  initial begin
    // Reset values
    cycle();
    cycle();
    @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_dri", 32'(sw_data_ready_in), 32'd0);
    check("rst_sw_in", 32'(sw_in), 32'd0);
    check("rst_err_credit", 32'(err_credit), 32'd0);
    check("rst_err_overflow", 32'(err_overflow), 32'd0);
    cycle();
    rst = 1'b0;
    cycle();

    // Configure, then five back-to-back sends on VC0 with four credits
    sw_config_done = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) tx_step(2'd0, 16'h1000 + 16'(i), 1'b1);
    tx_step(2'd0, 16'h1004, 1'b0);
    tx_step(2'd0, 16'h1004, 1'b0);
    sw_buffer_available = 2'b01;
    tx_step(2'd0, 16'h1004, 1'b0);
    sw_buffer_available = 2'b00;
    tx_step(2'd0, 16'h1004, 1'b1);
    tx_step(2'd0, 16'h1005, 1'b0);
    tx_valid = 1'b0;

    // VC1 down to one credit, then accept and return on the same edge
    for (int i = 0; i < 3; i++) tx_step(2'd1, 16'h2000 + 16'(i), 1'b1);
    sw_buffer_available = 2'b10;
    tx_step(2'd1, 16'h2003, 1'b1);
    sw_buffer_available = 2'b00;
    tx_step(2'd1, 16'h2004, 1'b1);
    tx_step(2'd1, 16'h2005, 1'b0);
    tx_valid = 1'b0;

    // Credit return beyond the maximum saturates and flags
    for (int i = 0; i < 4; i++) credit_pulse(2'b10);
    @(negedge clk);
    check("err_credit_before", 32'(err_credit), 32'd0);
    cycle();
    credit_pulse(2'b10);
    @(negedge clk);
    check("err_credit_set", 32'(err_credit), 32'd1);
    cycle();
    for (int i = 0; i < 4; i++) tx_step(2'd1, 16'h3000 + 16'(i), 1'b1);
    tx_step(2'd1, 16'h3004, 1'b0);
    tx_valid = 1'b0;

    // Round-robin receive order with a stalled consumer first
    rx_push(2'd0, 16'hA000, 1'b0);
    rx_push(2'd0, 16'hA001, 1'b0);
    rx_push(2'd0, 16'hA002, 1'b0);
    rx_push(2'd0, 16'hA003, 1'b0);
    rx_push(2'd1, 16'hB000, 1'b0);
    @(negedge clk);
    check("rx_hold_head", 32'(rx_flit), 32'(mk(2'd0, 16'hA000)));
    cycle();
    rx_q.push_back(mk(2'd0, 16'hA000));
    rx_q.push_back(mk(2'd1, 16'hB000));
    rx_q.push_back(mk(2'd0, 16'hA001));
    rx_q.push_back(mk(2'd0, 16'hA002));
    rx_q.push_back(mk(2'd0, 16'hA003));
    rx_drain();

    // Full FIFO: drop without pop, accept with concurrent pop
    for (int i = 0; i < 4; i++) rx_push(2'd0, 16'hC000 + 16'(i), 1'b1);
    @(negedge clk);
    check("err_overflow_before", 32'(err_overflow), 32'd0);
    cycle();
    rx_push(2'd0, 16'hC004, 1'b0);
    @(negedge clk);
    check("err_overflow_set", 32'(err_overflow), 32'd1);
    cycle();
    rx_ready = 1'b1;
    rx_push(2'd0, 16'hC005, 1'b1);
    rx_ready = 1'b0;
    rx_drain();
    check("err_overflow_sticky", 32'(err_overflow), 32'd1);

    // End-of-packet pop
    rx_push(2'd1, 16'hD000, 1'b1);
    rx_ready = 1'b1;
    rx_eop   = 1'b1;
    cycle();
    rx_ready = 1'b0;
    rx_eop   = 1'b0;
    @(negedge clk);
    check("packet_sent_pulse", 32'(sw_packet_sent), 32'd1);
    cycle();
    @(negedge clk);
    check("packet_sent_cleared", 32'(sw_packet_sent), 32'd0);
    cycle();

    // Configuration drop and reload
    credit_pulse(2'b10);
    credit_pulse(2'b10);
    sw_config_done = 1'b0;
    tx_step(2'd1, 16'h4000, 1'b1);
    tx_step(2'd1, 16'h4001, 1'b0);
    tx_step(2'd1, 16'h4001, 1'b0);
    sw_config_done = 1'b1;
    tx_step(2'd1, 16'h4001, 1'b0);
    for (int i = 0; i < 4; i++) tx_step(2'd0, 16'h5000 + 16'(i), 1'b1);
    tx_step(2'd0, 16'h5004, 1'b0);
    for (int i = 0; i < 4; i++) tx_step(2'd1, 16'h5100 + 16'(i), 1'b1);
    tx_step(2'd1, 16'h5104, 1'b0);
    tx_valid = 1'b0;
    cycle();
    check("tx_q_empty", 32'(tx_q.size()), 32'd0);

    // Reset in the middle of traffic
    rx_push(2'd0, 16'hE000, 1'b0);
    credit_pulse(2'b10);
    tx_step(2'd1, 16'hE100, 1'b1);
    tx_valid = 1'b0;
    rst = 1'b1;
    tx_q.delete();
    rx_q.delete();
    @(negedge clk);
    check("mid_rst_dri", 32'(sw_data_ready_in), 32'd0);
    check("mid_rst_sw_in", 32'(sw_in), 32'd0);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_err_credit", 32'(err_credit), 32'd0);
    check("mid_rst_err_overflow", 32'(err_overflow), 32'd0);
    cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx_ready", 32'(tx_ready), 32'd0);
    check("post_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("post_rst_granted", 32'(sw_credit_granted), 32'd0);
    cycle();
    @(negedge clk);
    check("post_rst_reloaded", 32'(tx_ready), 32'd1);
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
